// File: rtl/signed_bcd_converter.sv
// signed_bcd_converter: serial double-dabble conversion of a signed operand into sign plus 3-digit BCD magnitude.
// Define BCD_SATURATE_EN to report 399 instead of 0 on bcd when the magnitude overflows.
module signed_bcd_converter #(
  parameter int IN_W = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] value,
  output logic            busy,
  output logic            done,
  output logic [9:0]      bcd,
  output logic            negative,
  output logic            overflow
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam int CW = $clog2(IN_W);
  localparam logic [CW-1:0] LAST = CW'(IN_W - 1);
`ifdef BCD_SATURATE_EN
  localparam logic [9:0] OVF_BCD = 10'b11_1001_1001;
`else
  localparam logic [9:0] OVF_BCD = 10'b0;
`endif
  logic [1:0]      r_state;
  logic [IN_W-1:0] r_mag;
  logic [15:0]     r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_sign;
  logic [15:0]     w_adj;
  logic            w_ovf;
  function automatic logic [3:0] add3(input logic [3:0] d);
    return d >= 4'd5 ? d + 4'd3 : d;
  endfunction
  always_comb begin
    w_adj = {add3(r_acc[15:12]), add3(r_acc[11:8]), add3(r_acc[7:4]), add3(r_acc[3:0])};
    w_ovf = (|r_acc[15:12]) | (r_acc[11:8] > 4'd3);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_mag    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_mag   <= value[IN_W-1] ? -value : value;
          r_sign  <= value[IN_W-1];
          r_acc   <= '0;
          r_cnt   <= '0;
          busy    <= 1'b1;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_acc   <= (w_adj << 1) | 16'(r_mag[IN_W-1]);
          r_mag   <= r_mag << 1;
          r_cnt   <= r_cnt + 1'b1;
          r_state <= r_cnt == LAST ? S_DONE : S_SHIFT;
        end
        S_DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          bcd      <= w_ovf ? OVF_BCD : r_acc[9:0];
          negative <= r_sign & (|r_acc);
          overflow <= w_ovf;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_signed_bcd_converter.sv
// tb_signed_bcd_converter: scoreboard-driven bench for signed_bcd_converter at IN_W=11.
module tb_signed_bcd_converter;
  localparam int IN_W = 11;
`ifdef BCD_SATURATE_EN
  localparam logic [9:0] SAT = 10'b11_1001_1001;
`else
  localparam logic [9:0] SAT = 10'b0;
`endif
  typedef struct {logic [9:0] bcd; logic neg; logic ovf;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [IN_W-1:0] value = '0;
  logic busy, done, negative, overflow;
  logic [9:0] bcd;
  exp_t sb[$];
  int errs = 0, checks = 0;
  signed_bcd_converter #(.IN_W(IN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .busy(busy), .done(done), .bcd(bcd), .negative(negative), .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input int v);
    exp_t e;
    int m;
    m = v < 0 ? -v : v;
    e.neg = v < 0;
    e.ovf = m > 399;
    e.bcd = e.ovf ? SAT : 10'((m / 100) * 256 + ((m / 10) % 10) * 16 + m % 10);
    return e;
  endfunction
  task automatic send(input int v);
    @(negedge clk);
    value = IN_W'(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic test_reset();
    start = 1'b1;
    value = IN_W'(5);
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, bcd, negative, overflow} !== 14'b0) begin
      errs++;
      $display("FAIL reset_state: got busy=%b done=%b bcd=%h neg=%b ovf=%b, want all zero", busy, done, bcd, negative, overflow);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_values();
    int vals[12] = '{123, -57, 0, 399, 400, -1024, 1023, -1, 9, -400, 100, -399};
    int cyc;
    exp_t e;
    foreach (vals[i]) begin
      sb.push_back(model(vals[i]));
      send(vals[i]);
      wait_done(cyc);
      checks++;
      if (cyc >= 40) begin
        errs++;
        $display("FAIL value_%0d: no done pulse within 40 cycles", vals[i]);
        void'(sb.pop_front());
      end else begin
        e = sb.pop_front();
        if ({bcd, negative, overflow} !== {e.bcd, e.neg, e.ovf}) begin
          errs++;
          $display("FAIL value_%0d: got bcd=%h neg=%b ovf=%b, want bcd=%h neg=%b ovf=%b", vals[i], bcd, negative, overflow, e.bcd, e.neg, e.ovf);
        end
        if (i == 0) begin
          checks++;
          if (cyc + 1 != IN_W + 2) begin
            errs++;
            $display("FAIL latency: got %0d cycles, want %0d", cyc + 1, IN_W + 2);
          end
        end
        if (i == 11) begin
          repeat (4) @(negedge clk);
          checks++;
          if ({bcd, negative, overflow, done} !== {e.bcd, e.neg, e.ovf, 1'b0}) begin
            errs++;
            $display("FAIL hold: got bcd=%h neg=%b ovf=%b done=%b, want bcd=%h neg=%b ovf=%b done=0", bcd, negative, overflow, done, e.bcd, e.neg, e.ovf);
          end
        end
      end
    end
  endtask
  task automatic test_back_to_back();
    int ndone = 0, v;
    exp_t e;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL b2b_extra_done: got done with empty scoreboard, want none");
        end else begin
          e = sb.pop_front();
          if ({bcd, negative, overflow} !== {e.bcd, e.neg, e.ovf}) begin
            errs++;
            $display("FAIL b2b_result: got bcd=%h neg=%b ovf=%b, want bcd=%h neg=%b ovf=%b", bcd, negative, overflow, e.bcd, e.neg, e.ovf);
          end
        end
      end
      if (i < 20) begin
        v = (i % 2) ? -(100 + i) : 100 + i;
        value = IN_W'(v);
        start = 1'b1;
        if (i == 0 || i == IN_W + 2) sb.push_back(model(v));
      end else start = 1'b0;
    end
    checks++;
    if (ndone != 2 || sb.size() != 0) begin
      errs++;
      $display("FAIL b2b_count: got %0d dones (%0d left), want 2 (0 left)", ndone, sb.size());
    end
    sb.delete();
  endtask
  task automatic test_abort_reset();
    int cyc, ndone = 0;
    exp_t e;
    send(777);
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL abort_busy_before: got busy=%b, want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, bcd, negative, overflow} !== 14'b0) begin
      errs++;
      $display("FAIL abort_outputs: got busy=%b done=%b bcd=%h neg=%b ovf=%b, want all zero", busy, done, bcd, negative, overflow);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errs++;
      $display("FAIL abort_no_done: got %0d dones, want 0", ndone);
    end
    sb.push_back(model(42));
    send(42);
    wait_done(cyc);
    checks++;
    e = sb.pop_front();
    if (cyc >= 40 || {bcd, negative, overflow} !== {e.bcd, e.neg, e.ovf}) begin
      errs++;
      $display("FAIL after_abort_42: got bcd=%h neg=%b ovf=%b (cyc %0d), want bcd=%h neg=%b ovf=%b", bcd, negative, overflow, cyc, e.bcd, e.neg, e.ovf);
    end
  endtask
  initial begin
    test_reset();
    test_values();
    test_back_to_back();
    test_abort_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/signed_bcd_converter.md
SIGNED_BCD_CONVERTER -- requirements
Module: signed_bcd_converter

Interface
REQ-001 SHALL have parameter IN_W, default 11: width of the two's-complement input; legal range 4..13.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to convert; sampled only in IDLE.
REQ-005 SHALL have port value  input  IN_W  signed operand; sampled on the cycle start is accepted.
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress (SHIFT or DONE).
REQ-007 SHALL have port done  output  1  one-cycle pulse when the result outputs update.
REQ-008 SHALL have port bcd  output  10  {hundreds[1:0], tens[3:0], ones[3:0]} of the magnitude, feeding the display stage.
REQ-009 SHALL have port negative  output  1  sign of the converted value.
REQ-010 SHALL have port overflow  output  1  magnitude exceeds 399.

Function
REQ-011 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-012 IDLE with start=1 SHALL capture magnitude = |value| as IN_W-bit unsigned, and capture sign = value[IN_W-1].
REQ-013 The IDLE capture SHALL clear the internal 4-digit BCD accumulator and go to SHIFT.
REQ-014 The magnitude of -2^(IN_W-1) SHALL be 2^(IN_W-1), with no wrap.
REQ-015 SHIFT SHALL run exactly IN_W cycles, one double-dabble step per cycle.
REQ-016 Each double-dabble step SHALL add 3 to every accumulator digit >= 5, then shift the accumulator left by 1 with the magnitude MSB shifted in.
REQ-017 After the last SHIFT cycle the FSM SHALL enter DONE.
REQ-018 DONE SHALL pulse done=1 for one cycle, update bcd/negative/overflow in that same cycle, then return to IDLE.
REQ-019 Latency SHALL be IN_W+2 cycles from the start-accept edge to the done-high cycle; a new start SHALL be accepted on the cycle after DONE.
REQ-020 start while busy=1 SHALL be ignored, with no queuing.
REQ-021 overflow SHALL be 1 when the thousands digit != 0 or the hundreds digit > 3.
REQ-022 When overflow=0, bcd SHALL equal the low 10 accumulator bits.
REQ-023 negative SHALL be sign AND (magnitude != 0); it SHALL also be valid when overflow=1.
REQ-024 bcd, negative and overflow SHALL hold their values between done pulses.
REQ-025 Every output SHALL be registered.

Reset
REQ-026 rst_n low SHALL, asynchronously and in any state, force IDLE and the following output values: busy=0, done=0, bcd=0, negative=0, overflow=0.
REQ-027 The internal accumulator and magnitude registers SHALL be cleared on reset.
REQ-028 Reset mid-conversion SHALL abort with no done pulse.
REQ-029 After reset deasserts, the first start accepted SHALL behave as a fresh conversion.

Configuration
REQ-030 Macro BCD_SATURATE_EN defined: with overflow=1, bcd SHALL be 10'b11_1001_1001 (399).
REQ-031 Macro BCD_SATURATE_EN undefined: with overflow=1, bcd SHALL be 10'b0.
REQ-032 All other behaviour SHALL be identical with and without BCD_SATURATE_EN.

Verification (IN_W=11)
REQ-033 value=123, start 1 cycle -> done high 13 cycles later; bcd=10'b01_0010_0011, negative=0, overflow=0.
REQ-034 value=-57 (11'h7C7) -> bcd=10'b00_0101_0111, negative=1, overflow=0; value=0 -> bcd=0, negative=0.
REQ-035 value=399 -> bcd=10'b11_1001_1001, overflow=0; value=400 -> overflow=1, bcd=0 (399 with BCD_SATURATE_EN).
REQ-036 value=-1024 (11'h400) -> overflow=1, negative=1; no wrap to 0.
REQ-037 start held high for 20 cycles with value changing after acceptance -> one done per IN_W+2 window; the result reflects the value present at acceptance.
REQ-038 rst_n pulsed low 5 cycles into SHIFT -> busy=0 immediately, no done; outputs 0; next conversion of 42 -> bcd=10'b00_0100_0010.
